// File: rtl/soc_event_pkg.sv
// rtl/soc_event_pkg.sv - shared constants for the SoC event arbiter and event-queue array
package soc_event_pkg;

    localparam int SOC_NB_EVENTS  = 8;
    localparam int SOC_FIFO_DEPTH = 4;

endpackage

// File: rtl/soc_event_rr_arbiter.sv
// rtl/soc_event_rr_arbiter.sv - round-robin arbiter, search starts after the last granted index
module soc_event_rr_arbiter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        found     = 1'b0;
        cand      = '0;
        grant_idx = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_grant) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant_valid = enable && found;
        grant       = '0;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Reset to N-1 so that index 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant <= IW'(N - 1);
        end else if (grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/soc_event_arbiter.sv
// rtl/soc_event_arbiter.sv - round-robin event collector feeding a valid/ready FIFO toward the FC
module soc_event_arbiter
    import soc_event_pkg::*;
#(
    parameter int NB_EVENTS  = SOC_NB_EVENTS,
    parameter int FIFO_DEPTH = SOC_FIFO_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NB_EVENTS-1:0]            event_req_i,
    output logic [NB_EVENTS-1:0]            event_ack_o,
    output logic                            evt_valid_o,
    input  logic                            evt_ready_i,
    output logic [$clog2(NB_EVENTS)-1:0]    evt_id_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

    localparam int ID_WIDTH  = $clog2(NB_EVENTS);
    localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    logic [ID_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [LVL_WIDTH-1:0] level;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 push_en;
    logic                 arb_en;

    assign full        = (level == LVL_WIDTH'(FIFO_DEPTH));
    assign evt_valid_o = (level != '0);
    assign pop         = evt_valid_o && evt_ready_i;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept a grant.
    assign push_en     = !full || pop;
    assign arb_en      = push_en && rstn_i;
    assign evt_id_o    = mem[rd_ptr];
    assign fifo_level_o = level;

    soc_event_rr_arbiter #(
        .N (NB_EVENTS)
    ) u_rr_arbiter (
        .clk         (clk_i),
        .rstn        (rstn_i),
        .req         (event_req_i),
        .enable      (arb_en),
        .grant       (event_ack_o),
        .grant_idx   (grant_idx),
        .grant_valid (push)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= grant_idx;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule
